// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ============================================================================
//  Module      : multicycle_ctrl_fsm_pkg
//  Description : State codes, opcodes, ALUOp codes and select encodings
//                shared by the multicycle controller and its datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_fsm_pkg;

    localparam logic [4:0] S_FETCH  = 5'd0;
    localparam logic [4:0] S_DECODE = 5'd1;
    localparam logic [4:0] S_RT1    = 5'd2;
    localparam logic [4:0] S_RT2    = 5'd3;
    localparam logic [4:0] S_SW     = 5'd4;
    localparam logic [4:0] S_LW1    = 5'd5;
    localparam logic [4:0] S_LW2    = 5'd6;
    localparam logic [4:0] S_J      = 5'd7;
    localparam logic [4:0] S_LI     = 5'd8;
    localparam logic [4:0] S_MOV    = 5'd9;
    localparam logic [4:0] S_JAL    = 5'd10;
    localparam logic [4:0] S_BEQ1   = 5'd11;
    localparam logic [4:0] S_BEQ2   = 5'd12;
    localparam logic [4:0] S_PUSH   = 5'd13;
    localparam logic [4:0] S_POP1   = 5'd14;
    localparam logic [4:0] S_POP2   = 5'd15;
    localparam logic [4:0] S_IRQ1   = 5'd16;
    localparam logic [4:0] S_IRQ2   = 5'd17;
    localparam logic [4:0] S_TRAP   = 5'd18;

    localparam logic [3:0] OP_LW   = 4'h0;
    localparam logic [3:0] OP_SW   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_J    = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_ALU5 = 4'h5;
    localparam logic [3:0] OP_ALU6 = 4'h6;
    localparam logic [3:0] OP_LI   = 4'h7;
    localparam logic [3:0] OP_ALU8 = 4'h8;
    localparam logic [3:0] OP_ALU9 = 4'h9;
    localparam logic [3:0] OP_ALUB = 4'hB;
    localparam logic [3:0] OP_JAL  = 4'hC;
    localparam logic [3:0] OP_PUSH = 4'hD;
    localparam logic [3:0] OP_POP  = 4'hE;
    localparam logic [3:0] OP_MOV  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_OP1 = 3'd1;
    localparam logic [2:0] ALU_OP2 = 3'd2;
    localparam logic [2:0] ALU_OP3 = 3'd3;
    localparam logic [2:0] ALU_OP4 = 3'd4;
    localparam logic [2:0] ALU_CMP = 3'd5;

    localparam logic [1:0] PCSRC_HOLD = 2'b00;
    localparam logic [1:0] PCSRC_INC  = 2'b01;
    localparam logic [1:0] PCSRC_VEC  = 2'b10;
    localparam logic [1:0] PCSRC_TGT  = 2'b11;

    localparam logic [1:0] MADDR_ALU = 2'b00;
    localparam logic [1:0] MADDR_PC  = 2'b01;
    localparam logic [1:0] MADDR_SP  = 2'b10;
    localparam logic [1:0] MADDR_ST  = 2'b11;

    localparam logic [1:0] RFWA_RD   = 2'b00;
    localparam logic [1:0] RFWA_LINK = 2'b01;
    localparam logic [1:0] RFWA_IMM  = 2'b10;

    localparam logic [2:0] RFWD_MEM  = 3'b000;
    localparam logic [2:0] RFWD_PC   = 3'b001;
    localparam logic [2:0] RFWD_MOV  = 3'b010;
    localparam logic [2:0] RFWD_ALU  = 3'b011;
    localparam logic [2:0] RFWD_IMM  = 3'b100;
    localparam logic [2:0] RFWD_IDLE = 3'b101;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_TIMEOUT = 2'b10
    } trap_cause_e;

    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_ALU8: return ALU_OP1;
            OP_ALU9: return ALU_OP2;
            OP_ALU5: return ALU_OP3;
            OP_ALU6: return ALU_OP4;
            OP_ALUB: return ALU_CMP;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_mem_state(input logic [4:0] s);
        return (s == S_FETCH) || (s == S_SW) || (s == S_LW1) ||
               (s == S_PUSH) || (s == S_POP1) || (s == S_IRQ1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_if.sv
// ============================================================================
//  Module      : multicycle_ctrl_fsm_if
//  Description : IR/memory/interrupt inputs and datapath strobes of the
//                multicycle controller; master = controller, slave = datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_fsm_if #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 4,
    parameter int STATE_W  = 5
);
    logic [OPCODE_W-1:0] Opcode;
    logic                MReady;
    logic                IrqReq;
    logic                IrqEn;

    logic [1:0]          PCSrc;
    logic [1:0]          MAddr;
    logic [1:0]          RFWA;
    logic [2:0]          RFWD;
    logic [1:0]          ALUInB;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                PCWrite, IRWrite, MDin, MRead, MWrite, RFRead, RDWrite;
    logic                SPWrite, AWrite, BWrite, ALUInA, ALUOutWrite, Branch;
    logic                SPRel, PshPop, IrqAck;
    logic [1:0]          TrapCause;
    logic [STATE_W-1:0]  CrtState;

    modport master (
        input  Opcode, MReady, IrqReq, IrqEn,
        output PCSrc, MAddr, RFWA, RFWD, ALUInB, ALUOp,
               PCWrite, IRWrite, MDin, MRead, MWrite, RFRead, RDWrite,
               SPWrite, AWrite, BWrite, ALUInA, ALUOutWrite, Branch,
               SPRel, PshPop, IrqAck, TrapCause, CrtState
    );

    modport slave (
        output Opcode, MReady, IrqReq, IrqEn,
        input  PCSrc, MAddr, RFWA, RFWD, ALUInB, ALUOp,
               PCWrite, IRWrite, MDin, MRead, MWrite, RFRead, RDWrite,
               SPWrite, AWrite, BWrite, ALUInA, ALUOutWrite, Branch,
               SPRel, PshPop, IrqAck, TrapCause, CrtState
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// ============================================================================
//  Module      : multicycle_ctrl_fsm_wait_timer
//  Description : Memory wait-state counter; flags hold and bus timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic mem_state_i,
    input  logic mready_i,
    output logic hold_o,
    output logic timeout_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_limit;

    // MReady is checked first so a completion at the limit still succeeds.
    assign at_limit  = (cnt_q == CNT_W'(TIMEOUT));
    assign timeout_o = mem_state_i & ~mready_i & at_limit;
    assign hold_o    = mem_state_i & ~mready_i & ~at_limit;
    assign cnt_d     = hold_o ? cnt_q + 1'b1 : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
//  Module      : multicycle_ctrl_fsm
//  Description : Moore control FSM for the stack/accumulator CPU with memory
//                wait-states, fetch-boundary interrupt and illegal/bus trap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 4,
    parameter int TIMEOUT  = 15,
    parameter int STATE_W  = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    multicycle_ctrl_fsm_if.master bus
);
    import multicycle_ctrl_fsm_pkg::*;

    logic [4:0]  state_q, state_d;
    trap_cause_e trap_q, trap_d;
    logic [3:0]  op_lo;
    logic        op_hi_set;
    logic        hold, timeout, irq_take;

    assign op_lo    = bus.Opcode[3:0];
    assign irq_take = bus.IrqReq & bus.IrqEn;

    generate
        if (OPCODE_W > 4) begin : g_op_hi
            assign op_hi_set = |bus.Opcode[OPCODE_W-1:4];
        end else begin : g_op_nohi
            assign op_hi_set = 1'b0;
        end
    endgenerate

    multicycle_ctrl_fsm_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .CLK         (CLK),
        .RST         (RST),
        .mem_state_i (is_mem_state(state_q)),
        .mready_i    (bus.MReady),
        .hold_o      (hold),
        .timeout_o   (timeout)
    );

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (op_hi_set) begin
                    state_d = S_TRAP;
                    trap_d  = TRAP_ILLEGAL;
                end else begin
                    case (op_lo)
                        OP_LW:   state_d = S_LW1;
                        OP_SW:   state_d = S_SW;
                        OP_J:    state_d = S_J;
                        OP_LI:   state_d = S_LI;
                        OP_MOV:  state_d = S_MOV;
                        OP_BEQ:  state_d = S_BEQ1;
                        OP_JAL:  state_d = S_JAL;
                        OP_PUSH: state_d = S_PUSH;
                        OP_POP:  state_d = S_POP1;
                        OP_ADD, OP_ALU5, OP_ALU6,
                        OP_ALU8, OP_ALU9, OP_ALUB: state_d = S_RT1;
                        default: begin
                            state_d = S_TRAP;
                            trap_d  = TRAP_ILLEGAL;
                        end
                    endcase
                end
            end
            S_RT1:  state_d = S_RT2;
            S_JAL:  state_d = S_LI;
            S_BEQ1: state_d = S_BEQ2;
            S_LW1:  state_d = S_LW2;
            S_POP1: state_d = S_POP2;
            S_IRQ1: state_d = S_IRQ2;
            default: state_d = S_FETCH;
        endcase

        // IRQ2 is excluded so the handler's first instruction is always fetched.
        if (state_d == S_FETCH && state_q != S_IRQ2 && irq_take) begin
            state_d = S_IRQ1;
        end

        if (hold) begin
            state_d = state_q;
        end else if (timeout) begin
            state_d = S_TRAP;
            trap_d  = TRAP_TIMEOUT;
        end

        if (state_d == S_FETCH) begin
            trap_d = TRAP_NONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
        end
    end

    assign bus.CrtState  = STATE_W'(state_q);
    assign bus.TrapCause = trap_q;

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MDin        = 1'b0;
        bus.MRead       = 1'b0;
        bus.MWrite      = 1'b0;
        bus.RFRead      = 1'b0;
        bus.RDWrite     = 1'b0;
        bus.SPWrite     = 1'b0;
        bus.AWrite      = 1'b0;
        bus.BWrite      = 1'b0;
        bus.ALUInA      = 1'b0;
        bus.ALUOutWrite = 1'b0;
        bus.Branch      = 1'b0;
        bus.SPRel       = 1'b0;
        bus.PshPop      = 1'b0;
        bus.IrqAck      = 1'b0;
        bus.ALUInB      = 2'b00;
        bus.PCSrc       = PCSRC_HOLD;
        bus.MAddr       = MADDR_PC;
        bus.RFWA        = RFWA_RD;
        bus.RFWD        = RFWD_IDLE;
        bus.ALUOp       = '0;
        // Reset overrides the FETCH decode so no strobe leaks while RST is high.
        if (!RST) begin
            case (state_q)
                S_FETCH: begin
                    bus.MRead   = 1'b1;
                    bus.IRWrite = 1'b1;
                    bus.PCSrc   = PCSRC_INC;
                end
                S_DECODE: begin
                    bus.RFRead  = 1'b1;
                    bus.AWrite  = 1'b1;
                    bus.BWrite  = 1'b1;
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = PCSRC_INC;
                    bus.ALUOp   = ALUOP_W'(alu_op_of(op_lo));
                end
                S_RT1: bus.ALUOutWrite = 1'b1;
                S_RT2: begin
                    bus.RDWrite = 1'b1;
                    bus.RFWD    = RFWD_ALU;
                    bus.RFWA    = RFWA_RD;
                end
                S_SW: begin
                    bus.MDin   = 1'b1;
                    bus.MWrite = 1'b1;
                    bus.MAddr  = MADDR_ST;
                end
                S_LW1: begin
                    bus.MRead = 1'b1;
                    bus.MAddr = MADDR_ALU;
                end
                S_LW2, S_POP2: begin
                    bus.RDWrite = 1'b1;
                    bus.RFWD    = RFWD_MEM;
                end
                S_J: begin
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = PCSRC_TGT;
                end
                S_LI: begin
                    bus.RDWrite = 1'b1;
                    bus.RFWA    = RFWA_IMM;
                    bus.RFWD    = RFWD_IMM;
                end
                S_MOV: begin
                    bus.RDWrite = 1'b1;
                    bus.RFWD    = RFWD_MOV;
                end
                S_JAL: begin
                    bus.RDWrite = 1'b1;
                    bus.RFWA    = RFWA_LINK;
                    bus.RFWD    = RFWD_PC;
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = PCSRC_TGT;
                end
                S_BEQ1: begin
                    bus.ALUOp  = ALUOP_W'(ALU_CMP);
                    bus.ALUInA = 1'b1;
                    bus.Branch = 1'b1;
                    bus.PCSrc  = PCSRC_TGT;
                end
                S_BEQ2: begin
                    bus.Branch = 1'b1;
                    bus.PCSrc  = PCSRC_TGT;
                end
                S_PUSH: begin
                    bus.SPWrite = 1'b1;
                    bus.MDin    = 1'b1;
                    bus.MWrite  = 1'b1;
                    bus.MAddr   = MADDR_SP;
                end
                S_POP1: begin
                    bus.SPWrite = 1'b1;
                    bus.PshPop  = 1'b1;
                    bus.MRead   = 1'b1;
                end
                S_IRQ1: begin
                    bus.SPWrite = 1'b1;
                    bus.MWrite  = 1'b1;
                    bus.MAddr   = MADDR_SP;
                    bus.RFWD    = RFWD_PC;
                end
                S_IRQ2: begin
                    bus.IrqAck  = 1'b1;
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = PCSRC_VEC;
                end
                S_TRAP: begin
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = PCSRC_VEC;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// ============================================================================
//  Module      : tb_multicycle_ctrl_fsm
//  Description : Scoreboard bench for the multicycle controller FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl_fsm;
    import multicycle_ctrl_fsm_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    multicycle_ctrl_fsm_if #(.OPCODE_W(4), .ALUOP_W(4), .STATE_W(5)) bus ();

    multicycle_ctrl_fsm #(
        .OPCODE_W(4), .ALUOP_W(4), .TIMEOUT(15), .STATE_W(5)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic pcwrite, irwrite, mdin, mread, mwrite, rfread, rdwrite, spwrite;
        logic awrite, bwrite, aluina, aluoutwrite, branch, sprel, pshpop, irqack;
        logic [1:0] pcsrc, maddr, rfwa;
        logic [2:0] rfwd;
        logic [3:0] aluop;
        logic [1:0] trap;
    } outs_t;

    typedef struct {
        logic [3:0] opc;
        logic       mready, irqreq, irqen, rst;
    } stim_t;

    typedef struct {
        logic [4:0] st;
        outs_t      outs;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic logic [3:0] ref_aluop(input logic [3:0] opc);
        case (opc)
            4'h8: return 4'd1;
            4'h9: return 4'd2;
            4'h5: return 4'd3;
            4'h6: return 4'd4;
            4'hB: return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    // Reference output table written directly from the state/strobe list.
    function automatic outs_t model(input logic [4:0] st, input logic [3:0] opc,
                                    input logic [1:0] trap, input logic rst);
        outs_t o;
        o       = '0;
        o.maddr = 2'b01;
        o.rfwd  = 3'b101;
        o.trap  = trap;
        if (!rst) begin
            case (st)
                S_FETCH:  begin o.mread = 1; o.irwrite = 1; o.pcsrc = 2'b01; end
                S_DECODE: begin o.rfread = 1; o.awrite = 1; o.bwrite = 1; o.pcwrite = 1;
                                o.pcsrc = 2'b01; o.aluop = ref_aluop(opc); end
                S_RT1:    o.aluoutwrite = 1;
                S_RT2:    begin o.rdwrite = 1; o.rfwd = 3'b011; o.rfwa = 2'b00; end
                S_SW:     begin o.mdin = 1; o.mwrite = 1; o.maddr = 2'b11; end
                S_LW1:    begin o.mread = 1; o.maddr = 2'b00; end
                S_LW2:    begin o.rdwrite = 1; o.rfwd = 3'b000; end
                S_J:      begin o.pcwrite = 1; o.pcsrc = 2'b11; end
                S_LI:     begin o.rdwrite = 1; o.rfwa = 2'b10; o.rfwd = 3'b100; end
                S_MOV:    begin o.rdwrite = 1; o.rfwd = 3'b010; end
                S_JAL:    begin o.rdwrite = 1; o.rfwa = 2'b01; o.rfwd = 3'b001;
                                o.pcwrite = 1; o.pcsrc = 2'b11; end
                S_BEQ1:   begin o.aluop = 4'd5; o.aluina = 1; o.branch = 1; o.pcsrc = 2'b11; end
                S_BEQ2:   begin o.branch = 1; o.pcsrc = 2'b11; end
                S_PUSH:   begin o.spwrite = 1; o.mdin = 1; o.mwrite = 1; o.maddr = 2'b10; end
                S_POP1:   begin o.spwrite = 1; o.pshpop = 1; o.mread = 1; end
                S_POP2:   begin o.rdwrite = 1; o.rfwd = 3'b000; end
                S_IRQ1:   begin o.spwrite = 1; o.mwrite = 1; o.maddr = 2'b10; o.rfwd = 3'b001; end
                S_IRQ2:   begin o.irqack = 1; o.pcwrite = 1; o.pcsrc = 2'b10; end
                S_TRAP:   begin o.pcwrite = 1; o.pcsrc = 2'b10; end
                default:  ;
            endcase
        end
        return o;
    endfunction

    function automatic outs_t observe();
        return {bus.PCWrite, bus.IRWrite, bus.MDin, bus.MRead, bus.MWrite, bus.RFRead,
                bus.RDWrite, bus.SPWrite, bus.AWrite, bus.BWrite, bus.ALUInA,
                bus.ALUOutWrite, bus.Branch, bus.SPRel, bus.PshPop, bus.IrqAck,
                bus.PCSrc, bus.MAddr, bus.RFWA, bus.RFWD, bus.ALUOp, bus.TrapCause};
    endfunction

    task automatic plan(input logic [4:0] st, input logic [3:0] opc, input logic mr,
                        input logic [1:0] trap = 2'b00, input logic irq = 1'b0,
                        input logic en = 1'b0, input logic rst = 1'b0);
        stim_t s;
        exp_t  e;
        s.opc = opc; s.mready = mr; s.irqreq = irq; s.irqen = en; s.rst = rst;
        e.st   = st;
        e.outs = model(st, opc, trap, rst);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply_next(output exp_t e, output outs_t o);
        stim_t s;
        @(negedge CLK);
        s = stim_q.pop_front();
        bus.Opcode = s.opc;
        bus.MReady = s.mready;
        bus.IrqReq = s.irqreq;
        bus.IrqEn  = s.irqen;
        RST        = s.rst;
        #1;
        e = exp_q.pop_front();
        o = observe();
    endtask

    task automatic test_reset();
        exp_t e; outs_t o; int n = 0;
        plan(S_FETCH, 4'h2, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        plan(S_FETCH, 4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        plan(S_FETCH, 4'h2, 1'b0);
        while (exp_q.size() > 0) begin
            apply_next(e, o); n++;
            checks++; if (bus.CrtState !== e.st) begin failures++;
                $display("FAIL reset_state step=%0d got=%0d exp=%0d", n, bus.CrtState, e.st); end
            checks++; if (o !== e.outs) begin failures++;
                $display("FAIL reset_outs step=%0d got=%h exp=%h", n, o, e.outs); end
        end
    endtask

    task automatic test_alu();
        exp_t e; outs_t o; int n = 0;
        logic [3:0] ops [7] = '{4'h2, 4'h8, 4'h9, 4'h5, 4'h6, 4'hB, 4'h2};
        foreach (ops[i]) begin
            plan(S_FETCH, ops[i], 1'b1);
            plan(S_DECODE, ops[i], 1'b1);
            plan(S_RT1, ops[i], 1'b1);
            plan(S_RT2, ops[i], 1'b1);
        end
        plan(S_FETCH, 4'hF, 1'b1);
        plan(S_DECODE, 4'hF, 1'b1);
        plan(S_MOV, 4'hF, 1'b1);
        while (exp_q.size() > 0) begin
            apply_next(e, o); n++;
            checks++; if (bus.CrtState !== e.st) begin failures++;
                $display("FAIL alu_state step=%0d got=%0d exp=%0d", n, bus.CrtState, e.st); end
            checks++; if (o !== e.outs) begin failures++;
                $display("FAIL alu_outs step=%0d got=%h exp=%h", n, o, e.outs); end
        end
    endtask

    task automatic test_load_wait();
        exp_t e; outs_t o; int n = 0;
        plan(S_FETCH, 4'h0, 1'b1);
        plan(S_DECODE, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) plan(S_LW1, 4'h0, 1'b0);
        plan(S_LW1, 4'h0, 1'b1);
        plan(S_LW2, 4'h0, 1'b1);
        while (exp_q.size() > 0) begin
            apply_next(e, o); n++;
            checks++; if (bus.CrtState !== e.st) begin failures++;
                $display("FAIL lw_state step=%0d got=%0d exp=%0d", n, bus.CrtState, e.st); end
            checks++; if (o !== e.outs) begin failures++;
                $display("FAIL lw_outs step=%0d got=%h exp=%h", n, o, e.outs); end
        end
    endtask

    task automatic test_store_timeout();
        exp_t e; outs_t o; int n = 0;
        plan(S_FETCH, 4'h1, 1'b1);
        plan(S_DECODE, 4'h1, 1'b1);
        for (int i = 0; i < 16; i++) plan(S_SW, 4'h1, 1'b0);
        plan(S_TRAP, 4'h1, 1'b0, 2'b10);
        plan(S_FETCH, 4'h1, 1'b0);
        while (exp_q.size() > 0) begin
            apply_next(e, o); n++;
            checks++; if (bus.CrtState !== e.st) begin failures++;
                $display("FAIL sw_timeout_state step=%0d got=%0d exp=%0d", n, bus.CrtState, e.st); end
            checks++; if (o !== e.outs) begin failures++;
                $display("FAIL sw_timeout_outs step=%0d got=%h exp=%h", n, o, e.outs); end
        end
    endtask

    task automatic test_stack_boundary();
        exp_t e; outs_t o; int n = 0;
        plan(S_FETCH, 4'hD, 1'b1);
        plan(S_DECODE, 4'hD, 1'b1);
        for (int i = 0; i < 15; i++) plan(S_PUSH, 4'hD, 1'b0);
        plan(S_PUSH, 4'hD, 1'b1);
        plan(S_FETCH, 4'hE, 1'b1);
        plan(S_DECODE, 4'hE, 1'b1);
        plan(S_POP1, 4'hE, 1'b1);
        plan(S_POP2, 4'hE, 1'b1);
        while (exp_q.size() > 0) begin
            apply_next(e, o); n++;
            checks++; if (bus.CrtState !== e.st) begin failures++;
                $display("FAIL stack_state step=%0d got=%0d exp=%0d", n, bus.CrtState, e.st); end
            checks++; if (o !== e.outs) begin failures++;
                $display("FAIL stack_outs step=%0d got=%h exp=%h", n, o, e.outs); end
        end
    endtask

    task automatic test_illegal_jumps();
        exp_t e; outs_t o; int n = 0;
        plan(S_FETCH, 4'hA, 1'b1);
        plan(S_DECODE, 4'hA, 1'b1);
        plan(S_TRAP, 4'hA, 1'b1, 2'b01);
        plan(S_FETCH, 4'h3, 1'b1);
        plan(S_DECODE, 4'h3, 1'b1);
        plan(S_J, 4'h3, 1'b1);
        plan(S_FETCH, 4'hC, 1'b1);
        plan(S_DECODE, 4'hC, 1'b1);
        plan(S_JAL, 4'hC, 1'b1);
        plan(S_LI, 4'hC, 1'b1);
        while (exp_q.size() > 0) begin
            apply_next(e, o); n++;
            checks++; if (bus.CrtState !== e.st) begin failures++;
                $display("FAIL illegal_state step=%0d got=%0d exp=%0d", n, bus.CrtState, e.st); end
            checks++; if (o !== e.outs) begin failures++;
                $display("FAIL illegal_outs step=%0d got=%h exp=%h", n, o, e.outs); end
        end
    endtask

    task automatic test_irq();
        exp_t e; outs_t o; int n = 0;
        plan(S_FETCH, 4'h4, 1'b1);
        plan(S_DECODE, 4'h4, 1'b1);
        plan(S_BEQ1, 4'h4, 1'b1, 2'b00, 1'b1, 1'b1);
        plan(S_BEQ2, 4'h4, 1'b1, 2'b00, 1'b1, 1'b1);
        plan(S_IRQ1, 4'h4, 1'b0);
        plan(S_IRQ1, 4'h4, 1'b1);
        plan(S_IRQ2, 4'h4, 1'b1);
        plan(S_FETCH, 4'h4, 1'b1);
        plan(S_DECODE, 4'h4, 1'b1);
        plan(S_BEQ1, 4'h4, 1'b1);
        plan(S_BEQ2, 4'h4, 1'b1, 2'b00, 1'b1, 1'b0);
        plan(S_FETCH, 4'h7, 1'b1, 2'b00, 1'b1, 1'b0);
        plan(S_DECODE, 4'h7, 1'b1);
        plan(S_LI, 4'h7, 1'b1);
        while (exp_q.size() > 0) begin
            apply_next(e, o); n++;
            checks++; if (bus.CrtState !== e.st) begin failures++;
                $display("FAIL irq_state step=%0d got=%0d exp=%0d", n, bus.CrtState, e.st); end
            checks++; if (o !== e.outs) begin failures++;
                $display("FAIL irq_outs step=%0d got=%h exp=%h", n, o, e.outs); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; outs_t o; int n = 0;
        plan(S_FETCH, 4'h0, 1'b1);
        plan(S_DECODE, 4'h0, 1'b1);
        plan(S_LW1, 4'h0, 1'b0);
        plan(S_LW1, 4'h0, 1'b0);
        plan(S_FETCH, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        plan(S_FETCH, 4'h2, 1'b1);
        plan(S_DECODE, 4'h2, 1'b1);
        plan(S_RT1, 4'h2, 1'b1);
        plan(S_RT2, 4'h2, 1'b1);
        plan(S_FETCH, 4'h2, 1'b0);
        while (exp_q.size() > 0) begin
            apply_next(e, o); n++;
            checks++; if (bus.CrtState !== e.st) begin failures++;
                $display("FAIL reset_mid_state step=%0d got=%0d exp=%0d", n, bus.CrtState, e.st); end
            checks++; if (o !== e.outs) begin failures++;
                $display("FAIL reset_mid_outs step=%0d got=%h exp=%h", n, o, e.outs); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Opcode = '0;
        bus.MReady = 1'b0;
        bus.IrqReq = 1'b0;
        bus.IrqEn  = 1'b0;
        test_reset();
        test_alu();
        test_load_wait();
        test_store_timeout();
        test_stack_boundary();
        test_illegal_jumps();
        test_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
